// File: rtl/mem_rmw_ctrl.sv
// Posted-store write buffer with read-modify-write drain to a line RAM, plus a combinational load path.
// Latency: a full-line store writes the cycle after acceptance; a sub-word store fetches, then writes one cycle later.
// Backpressure: wr_ready_o drops when the buffer is full; loads stall on RAW hazards, a full buffer, or while a drain is in flight.
module mem_rmw_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          WBUF_DEPTH = 2,
  parameter int unsigned MAP_ZERO   = 0
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              rd_valid_i,
  input  logic                              rd_sext_i,
  input  logic [1:0]                        rd_acc_i,
  input  logic [31:0]                       rd_addr_i,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic                              rd_stall_o,
  output logic                              rd_misalign_o,
  input  logic                              wr_valid_i,
  input  logic [1:0]                        wr_acc_i,
  input  logic [31:0]                       wr_addr_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  output logic                              wr_ready_o,
  output logic                              wr_misalign_o,
  output logic [31:0]                       mem_addr_r_o,
  input  logic [DATA_W-1:0]                 mem_data_r_i,
  output logic                              mem_wr_en_o,
  output logic [31:0]                       mem_addr_w_o,
  output logic [DATA_W-1:0]                 mem_data_w_o,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  localparam logic [31:0]      LANE_M   = 32'(BYTES - 1);
  localparam logic [31:0]      BASE     = 32'(MAP_ZERO);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_FETCH,
    ST_STORE
  } state_t;

  // RAM line address of a CPU byte address.
  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a & ~LANE_M) - BASE;
  endfunction

  // An access is misaligned if the address is not a multiple of its size;
  // doubles do not exist on a 32-bit line.
  function automatic logic misal(input logic [1:0] acc, input logic [31:0] a);
    logic m;
    case (acc)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = (DATA_W == 32) | (|a[2:0]);
    endcase
    return m;
  endfunction

  // LSB-aligned lane mask for an access size; a line-sized access covers everything.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] acc);
    logic [DATA_W-1:0] m;
    m = '0;
    case (acc)
      2'd0:    m[7:0]  = '1;
      2'd1:    m[15:0] = '1;
      2'd2:    m[31:0] = '1;
      default: m       = '1;
    endcase
    return m;
  endfunction

  // True when the access covers the whole line, so no fetch is needed.
  function automatic logic is_full(input logic [1:0] acc);
    return (acc == 2'd3) || ((acc == 2'd2) && (DATA_W == 32));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(WBUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           acc_q  [WBUF_DEPTH];
  logic [1:0]           acc_d  [WBUF_DEPTH];
  logic [31:0]          addr_q [WBUF_DEPTH];
  logic [31:0]          addr_d [WBUF_DEPTH];
  logic [DATA_W-1:0]    data_q [WBUF_DEPTH];
  logic [DATA_W-1:0]    data_d [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]    old_q, old_d;

  logic                 push, pop, hazard, defer, has_work;
  logic [1:0]           hd_acc, eff_acc;
  logic [31:0]          hd_addr, hd_line;
  logic [DATA_W-1:0]    hd_data, merged;
  logic [31:0]          rd_line;
  logic [DATA_W-1:0]    rd_ext;

  assign hd_acc  = acc_q[head_q];
  assign hd_addr = addr_q[head_q];
  assign hd_data = data_q[head_q];
  assign hd_line = line_of(hd_addr);
  assign rd_line = line_of(rd_addr_i);

  // Handshake, misalignment flags and the load stall decision.
  always_comb begin
    wr_misalign_o = wr_valid_i & misal(wr_acc_i, wr_addr_i);
    rd_misalign_o = rd_valid_i & misal(rd_acc_i, rd_addr_i);
    wr_ready_o    = (state_q != ST_RESET) && (count_q < FULL_CNT);
    // A misaligned store still completes its handshake but never enters the buffer.
    push          = wr_valid_i & wr_ready_o & ~wr_misalign_o;
    pop           = (state_q == ST_STORE);
    hazard        = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (vld_q[i] && (line_of(addr_q[i]) == rd_line)) hazard = 1'b1;
    end
    hazard        = hazard & rd_valid_i;
    rd_stall_o    = rd_valid_i & ~rd_misalign_o &
                    ((state_q != ST_IDLE) | hazard | (count_q == FULL_CNT));
    wbuf_count_o  = count_q;
  end

  // Drain FSM next state; a store arriving into an empty buffer is considered
  // immediately so that it can start draining on its acceptance edge.
  always_comb begin
    state_d  = state_q;
    has_work = (count_q != '0) | push;
    eff_acc  = (count_q != '0) ? hd_acc : wr_acc_i;
    // An independent load gets priority over the drain unless the buffer is full.
    defer    = rd_valid_i & ~hazard & (count_q < FULL_CNT);
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (has_work && !defer) state_d = is_full(eff_acc) ? ST_STORE : ST_FETCH;
      end
      ST_FETCH: state_d = ST_STORE;
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_RESET;
    endcase
  end

  // Write-buffer push/pop bookkeeping and old-line capture during a fetch.
  always_comb begin
    acc_d   = acc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    old_d   = old_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    if (push) begin
      acc_d[tail_q]  = wr_acc_i;
      addr_d[tail_q] = wr_addr_i;
      data_d[tail_q] = wr_data_i;
      vld_d[tail_q]  = 1'b1;
      tail_d         = ptr_inc(tail_q);
    end
    if (state_q == ST_FETCH) old_d = mem_data_r_i;
  end

  // Merge the head store into the fetched line; line-sized stores bypass the merge.
  always_comb begin
    logic [OFF_W+2:0]  sh;
    logic [DATA_W-1:0] m;
    sh = {hd_addr[OFF_W-1:0], 3'b000};
    m  = size_mask(hd_acc);
    if (is_full(hd_acc)) merged = hd_data;
    else                 merged = (old_q & ~(m << sh)) | ((hd_data & m) << sh);
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    logic [OFF_W+2:0]  sh;
    logic [DATA_W-1:0] line_sh, m, top;
    logic              neg;
    sh      = {rd_addr_i[OFF_W-1:0], 3'b000};
    line_sh = mem_data_r_i >> sh;
    m       = size_mask(rd_acc_i);
    top     = m & ~(m >> 1);
    neg     = rd_sext_i & (|(line_sh & top));
    rd_ext  = (line_sh & m) | (neg ? ~m : '0);
  end

  // RAM-side outputs: read port shared by fetch and unstalled loads.
  always_comb begin
    mem_addr_r_o = '0;
    rd_data_o    = '0;
    mem_wr_en_o  = 1'b0;
    mem_addr_w_o = '0;
    mem_data_w_o = '0;
    if (state_q == ST_FETCH) begin
      mem_addr_r_o = hd_line;
    end else if (rd_valid_i && !rd_stall_o && !rd_misalign_o) begin
      mem_addr_r_o = rd_line;
      rd_data_o    = rd_ext;
    end
    if (state_q == ST_STORE) begin
      mem_wr_en_o  = 1'b1;
      mem_addr_w_o = hd_line;
      mem_data_w_o = merged;
    end
  end

  // State and buffer registers; reset discards any buffered stores.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_RESET;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      old_q   <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        acc_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      old_q   <= old_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl with a behavioural async-read/sync-write RAM.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Default parameters: 32-bit lines, two-entry write buffer, no address offset.
module tb_mem_rmw_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        rd_valid_i, rd_sext_i;
  logic [1:0]  rd_acc_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_stall_o, rd_misalign_o;
  logic        wr_valid_i;
  logic [1:0]  wr_acc_i;
  logic [31:0] wr_addr_i, wr_data_i;
  logic        wr_ready_o, wr_misalign_o;
  logic [31:0] mem_addr_r_o, mem_data_r_i;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_w_o, mem_data_w_o;
  logic [1:0]  wbuf_count_o;

  logic [31:0] ram [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_rmw_ctrl #(.DATA_W(32), .WBUF_DEPTH(2), .MAP_ZERO(0)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .rd_valid_i(rd_valid_i), .rd_sext_i(rd_sext_i), .rd_acc_i(rd_acc_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_stall_o(rd_stall_o),
    .rd_misalign_o(rd_misalign_o),
    .wr_valid_i(wr_valid_i), .wr_acc_i(wr_acc_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o), .wr_misalign_o(wr_misalign_o),
    .mem_addr_r_o(mem_addr_r_o), .mem_data_r_i(mem_data_r_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_w_o(mem_addr_w_o),
    .mem_data_w_o(mem_data_w_o), .wbuf_count_o(wbuf_count_o)
  );

  // RAM model: async read, sync write; the bench can preload while the DUT is not writing.
  assign mem_data_r_i = ram[mem_addr_r_o[9:2]];
  always @(posedge clk_i) begin
    if (mem_wr_en_o)  ram[mem_addr_w_o[9:2]] <= mem_data_w_o;
    else if (pre_we)  ram[pre_idx] <= pre_dat;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    rd_valid_i = 1'b1; rd_sext_i = 1'b0; rd_acc_i = 2'd2; rd_addr_i = 32'h0;
    wr_valid_i = 1'b0; wr_acc_i = 2'd0; wr_addr_i = 32'h0; wr_data_i = 32'h0;
    pre_we = 1'b1; pre_idx = 8'h40; pre_dat = 32'h80FF_FFFF;

    // Reset held for two cycles
    step();
    pre_we = 1'b0;
    chk("rst_ready", {31'b0, wr_ready_o}, 32'd0);
    chk("rst_count", {30'b0, wbuf_count_o}, 32'd0);
    chk("rst_stall", {31'b0, rd_stall_o}, 32'd1);
    chk("rst_rdata", rd_data_o, 32'h0);
    chk("rst_wen",   {31'b0, mem_wr_en_o}, 32'd0);
    chk("rst_addr_w", mem_addr_w_o, 32'h0);
    step();
    chk("rst2_ready", {31'b0, wr_ready_o}, 32'd0);
    chk("rst2_count", {30'b0, wbuf_count_o}, 32'd0);

    // Release: first cycle still in reset state, ready from the next
    rstn_i = 1'b1; rd_valid_i = 1'b0;
    settle();
    chk("rel_ready0", {31'b0, wr_ready_o}, 32'd0);
    step();
    chk("rel_ready1", {31'b0, wr_ready_o}, 32'd1);
    chk("rel_count",  {30'b0, wbuf_count_o}, 32'd0);

    // Byte load from 0x103 over line 0x80FFFFFF
    rd_valid_i = 1'b1; rd_acc_i = 2'd0; rd_addr_i = 32'h103; rd_sext_i = 1'b1;
    settle();
    chk("ldb_sext", rd_data_o, 32'hFFFF_FF80);
    chk("ldb_stall", {31'b0, rd_stall_o}, 32'd0);
    chk("ldb_mis", {31'b0, rd_misalign_o}, 32'd0);
    chk("ldb_raddr", mem_addr_r_o, 32'h100);
    rd_sext_i = 1'b0;
    settle();
    chk("ldb_zext", rd_data_o, 32'h0000_0080);

    // Reload line 0x100 with 0x11223344
    rd_valid_i = 1'b0;
    pre_we = 1'b1; pre_idx = 8'h40; pre_dat = 32'h1122_3344;
    step();
    pre_we = 1'b0;

    // Byte store 0xAB to 0x101: fetch then merge-write
    wr_valid_i = 1'b1; wr_acc_i = 2'd0; wr_addr_i = 32'h101; wr_data_i = 32'h0000_00AB;
    settle();
    chk("stb_ready", {31'b0, wr_ready_o}, 32'd1);
    chk("stb_mis", {31'b0, wr_misalign_o}, 32'd0);
    step();
    wr_valid_i = 1'b0;
    settle();
    chk("stb_count1", {30'b0, wbuf_count_o}, 32'd1);
    chk("stb_fetch_addr", mem_addr_r_o, 32'h100);
    chk("stb_fetch_wen", {31'b0, mem_wr_en_o}, 32'd0);
    step();
    chk("stb_wen", {31'b0, mem_wr_en_o}, 32'd1);
    chk("stb_addr_w", mem_addr_w_o, 32'h100);
    chk("stb_data_w", mem_data_w_o, 32'h1122_AB44);
    step();
    chk("stb_count0", {30'b0, wbuf_count_o}, 32'd0);
    chk("stb_wen_off", {31'b0, mem_wr_en_o}, 32'd0);
    chk("stb_ram", ram[8'h40], 32'h1122_AB44);

    // Half loads from the merged line
    rd_valid_i = 1'b1; rd_acc_i = 2'd1; rd_addr_i = 32'h100; rd_sext_i = 1'b1;
    settle();
    chk("ldh_lo_sext", rd_data_o, 32'hFFFF_AB44);
    rd_addr_i = 32'h102;
    settle();
    chk("ldh_hi_sext", rd_data_o, 32'h0000_1122);
    rd_valid_i = 1'b0; rd_sext_i = 1'b0;

    // RAW hazard: word store then immediate load of the same line
    wr_valid_i = 1'b1; wr_acc_i = 2'd2; wr_addr_i = 32'h200; wr_data_i = 32'hDEAD_BEEF;
    step();
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b1; rd_acc_i = 2'd2; rd_addr_i = 32'h200;
    settle();
    chk("raw_stall", {31'b0, rd_stall_o}, 32'd1);
    chk("raw_wen", {31'b0, mem_wr_en_o}, 32'd1);
    chk("raw_rdata_stalled", rd_data_o, 32'h0);
    step();
    chk("raw_unstall", {31'b0, rd_stall_o}, 32'd0);
    chk("raw_rdata", rd_data_o, 32'hDEAD_BEEF);
    chk("raw_count", {30'b0, wbuf_count_o}, 32'd0);

    // Buffer fill with an unrelated load held: drain forced when full
    rd_addr_i = 32'h400;
    wr_valid_i = 1'b1; wr_acc_i = 2'd2; wr_addr_i = 32'h300; wr_data_i = 32'h0000_00A0;
    settle();
    chk("fill_ready0", {31'b0, wr_ready_o}, 32'd1);
    chk("fill_stall0", {31'b0, rd_stall_o}, 32'd0);
    step();
    wr_addr_i = 32'h304; wr_data_i = 32'h0000_00A1;
    settle();
    chk("fill_count1", {30'b0, wbuf_count_o}, 32'd1);
    chk("fill_wen1", {31'b0, mem_wr_en_o}, 32'd0);
    chk("fill_stall1", {31'b0, rd_stall_o}, 32'd0);
    step();
    wr_addr_i = 32'h308; wr_data_i = 32'h0000_00A2;
    settle();
    chk("fill_count2", {30'b0, wbuf_count_o}, 32'd2);
    chk("fill_ready2", {31'b0, wr_ready_o}, 32'd0);
    chk("fill_stall2", {31'b0, rd_stall_o}, 32'd1);
    step();
    chk("drain0_wen", {31'b0, mem_wr_en_o}, 32'd1);
    chk("drain0_addr", mem_addr_w_o, 32'h300);
    chk("drain0_data", mem_data_w_o, 32'h0000_00A0);
    chk("drain0_ready", {31'b0, wr_ready_o}, 32'd0);
    step();
    chk("pop0_count", {30'b0, wbuf_count_o}, 32'd1);
    chk("pop0_ready", {31'b0, wr_ready_o}, 32'd1);
    chk("pop0_wen", {31'b0, mem_wr_en_o}, 32'd0);
    step();
    wr_valid_i = 1'b0; rd_valid_i = 1'b0;
    settle();
    chk("push2_count", {30'b0, wbuf_count_o}, 32'd2);
    chk("ram_300", ram[8'hC0], 32'h0000_00A0);
    step();
    chk("drain1_addr", mem_addr_w_o, 32'h304);
    chk("drain1_data", mem_data_w_o, 32'h0000_00A1);
    step();
    chk("pop1_count", {30'b0, wbuf_count_o}, 32'd1);
    step();
    chk("drain2_wen", {31'b0, mem_wr_en_o}, 32'd1);
    chk("drain2_addr", mem_addr_w_o, 32'h308);
    step();
    chk("pop2_count", {30'b0, wbuf_count_o}, 32'd0);
    chk("ram_304", ram[8'hC1], 32'h0000_00A1);
    chk("ram_308", ram[8'hC2], 32'h0000_00A2);

    // Misaligned half store is acknowledged but dropped
    wr_valid_i = 1'b1; wr_acc_i = 2'd1; wr_addr_i = 32'h3; wr_data_i = 32'h0000_5555;
    settle();
    chk("mis_st_flag", {31'b0, wr_misalign_o}, 32'd1);
    chk("mis_st_ready", {31'b0, wr_ready_o}, 32'd1);
    step();
    wr_valid_i = 1'b0;
    settle();
    chk("mis_st_count", {30'b0, wbuf_count_o}, 32'd0);
    chk("mis_st_flag_off", {31'b0, wr_misalign_o}, 32'd0);
    step();
    chk("mis_st_wen", {31'b0, mem_wr_en_o}, 32'd0);

    // Double load on a 32-bit line, and a misaligned half load
    rd_valid_i = 1'b1; rd_acc_i = 2'd3; rd_addr_i = 32'h0;
    settle();
    chk("mis_ld_flag", {31'b0, rd_misalign_o}, 32'd1);
    chk("mis_ld_data", rd_data_o, 32'h0);
    chk("mis_ld_stall", {31'b0, rd_stall_o}, 32'd0);
    rd_acc_i = 2'd1; rd_addr_i = 32'h101;
    settle();
    chk("mis_ldh_flag", {31'b0, rd_misalign_o}, 32'd1);
    chk("mis_ldh_data", rd_data_o, 32'h0);
    rd_valid_i = 1'b0; rd_acc_i = 2'd3;
    settle();
    chk("mis_ld_qual", {31'b0, rd_misalign_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
